uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver that drives the LED display. It adds configurable data width, parity, stop-bit count and an input synchroniser. It also adds mid-bit start validation, framing/parity/break detection, and a valid/ready output handshake with overrun reporting. It sits between the board RXD pin and any byte consumer (LED register, command parser, FIFO).

Parameters:
CLKS_PER_BIT, 5208, CLK cycles per bit (100 MHz / 19200 baud); legal range is 4 or more.
DATA_BITS, 8, data bits per frame; legal range is 5..9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits checked; legal values are 1 or 2.

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-low reset (RESET==0 resets on the CLK edge)
RXD  input  1  asynchronous serial line, idle high
DATA  output  DATA_BITS  received word, LSB = first bit on the line
VALID  output  1  DATA/flags hold a word not yet accepted
READY  input  1  consumer accepts the word when VALID&&READY at a CLK edge
PARITY_ERR  output  1  parity mismatch for the word in DATA (0 when PARITY_MODE==0)
FRAME_ERR  output  1  a stop bit was sampled low for the word in DATA
BREAK  output  1  the word in DATA is a break (all data bits 0, first stop bit 0)
OVERRUN  output  1  one-cycle pulse: a completed frame was dropped
BUSY  output  1  high while the FSM is not in IDLE

Behaviour:
- Reset (RESET==0 at a CLK edge): FSM goes to IDLE; counters are 0; synchroniser flops are set to 1. Output reset values: DATA=0, VALID=0, PARITY_ERR=0, FRAME_ERR=0, BREAK=0, OVERRUN=0, BUSY=0. Reset mid-frame abandons the frame with no output.
- Synchroniser: two flops on RXD. rxd_s lags RXD by 2 cycles. The FSM uses only rxd_s.
- Bit timer: clk_cnt is $clog2(CLKS_PER_BIT) bits wide. It reloads to 0 on every state entry. Its "tick" is clk_cnt==CLKS_PER_BIT-1, except in START where the tick is clk_cnt==CLKS_PER_BIT/2-1 (integer division).
- FSM states:
  - IDLE: on rxd_s==0, go to START.
  - START: on tick, if rxd_s==1 it is a glitch: return to IDLE with no flags. Otherwise go to DATA with bit_cnt=0.
  - DATA: on each tick, shift rxd_s into shift[bit_cnt] and increment bit_cnt. After bit DATA_BITS-1, go to PARITY if PARITY_MODE!=0, else to STOP.
  - PARITY: on tick, perr = (^shift ^ rxd_s) for even, or its inverse for odd.
  - STOP: one tick per stop bit. ferr |= (rxd_s==0) on each tick. After the last stop bit, complete the frame. Next state is BRK_WAIT if brk, else IDLE.
  - BRK_WAIT: stay until rxd_s==1, then go to IDLE. A held-low line must not retrigger START.
- brk is set when shift==0 and the first stop bit is sampled 0. BREAK implies FRAME_ERR.
- Frame completion happens on the last STOP tick:
  - If VALID==0, or VALID&&READY on the same edge: DATA/flags load and VALID=1 on the next cycle (latency 1 CLK from the stop-bit sample).
  - Else: the new frame is discarded, DATA is unchanged, and OVERRUN=1 for exactly one cycle.
- Handshake: VALID&&READY with no completion on that edge gives VALID=0 next cycle. DATA and flags hold their values until the next load.
- Errored frames are delivered with their data. The payload is not zeroed.
- READY is ignored while VALID==0. DATA/flags are stable whenever VALID==1.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/EVEN/ODD constants.
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, BRK_WAIT).
  - Function for counter width.
- One sub-module, uart_bit_timer, holds clk_cnt with load/half/full tick outputs. It is reusable by the future parametrised transmitter.

Test Plan:
(All tests use CLKS_PER_BIT=16, RXD bit period 16 CLK unless stated.)
- 8N1, send 0xA5 with READY=1: VALID pulses 1 cycle, DATA=0xA5, all flags 0, VALID rises 1 CLK after the stop-bit centre sample.
- PARITY_MODE=1, send 0x07 with parity bit 0: DATA=0x07, PARITY_ERR=1. Repeat with parity bit 1: PARITY_ERR=0. With PARITY_MODE=2 the results invert.
- Glitch: RXD low for 5 CLK then high: no VALID, BUSY returns to 0 within 8 CLK of the start-bit synchronised edge.
- Break: hold RXD low for 30 bit times, then high: exactly one VALID with DATA=0x00, FRAME_ERR=1, BREAK=1, and no further frames until RXD returns high.
- Overrun: READY=0, send 0x11 then 0x22: DATA stays 0x11, OVERRUN pulses once at the second frame's end. Then READY=1: VALID drops next cycle.
- Reset: assert RESET=0 during DATA bit 3 of 0x3C: all outputs go to reset values next cycle. The next clean frame 0x3C is received correctly. Also run once with DATA_BITS=5, STOP_BITS=2, where a second stop bit sampled low gives FRAME_ERR=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: parity modes,
// receiver FSM encoding and a counter-width helper.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } uart_state_t;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clock cycles since the last load and flags the
// half-bit and full-bit points. Shared between receiver and transmitter.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt_r;

  // Cycle counter: restarts from zero on load, otherwise free-runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt_r <= {CW{1'b0}};
    end else if (load) begin
      clk_cnt_r <= {CW{1'b0}};
    end else begin
      clk_cnt_r <= clk_cnt_r + CW'(1);
    end
  end

  assign half_tick = (clk_cnt_r == HALF_LAST);
  assign full_tick = (clk_cnt_r == FULL_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop input synchroniser, mid-bit start
// validation, optional parity, 1 or 2 stop bits, break detection and a
// valid/ready output register with overrun reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 BREAK,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam logic [1:0]    PMODE     = 2'(PARITY_MODE);
  localparam int            BW        = cnt_width(DATA_BITS);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_t          state_r, state_next;
  logic [1:0]           sync_r;
  logic                 rxd_s;
  logic                 half_tick, full_tick, tick_s, load_s;
  logic                 complete_s;
  logic [BW-1:0]        bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 perr_r, ferr_r, brk_r;
  logic                 ferr_next_s, brk_next_s;

  // Two-flop synchroniser on the asynchronous line; idles high.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], RXD};
    end
  end

  assign rxd_s = sync_r[1];

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (CLK),
    .rst_n     (RESET),
    .load      (load_s),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // Stop-bit error flags including the bit being sampled right now, so the
  // completing tick can deliver them without an extra cycle.
  assign ferr_next_s = ferr_r | ~rxd_s;
  assign brk_next_s  = (bit_cnt_r == {BW{1'b0}}) ?
                       ((shift_r == {DATA_BITS{1'b0}}) && !rxd_s) : brk_r;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic, tick selection and frame-completion strobe.
  always_comb begin
    state_next = state_r;
    tick_s     = full_tick;
    complete_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxd_s) state_next = ST_START;
        else        state_next = ST_IDLE;
      end
      ST_START: begin
        tick_s = half_tick;
        if (half_tick) state_next = rxd_s ? ST_IDLE : ST_DATA;
        else           state_next = ST_START;
      end
      ST_DATA: begin
        if (full_tick && (bit_cnt_r == LAST_DATA))
          state_next = (PMODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
        else
          state_next = ST_DATA;
      end
      ST_PARITY: begin
        if (full_tick) state_next = ST_STOP;
        else           state_next = ST_PARITY;
      end
      ST_STOP: begin
        if (full_tick && (bit_cnt_r == LAST_STOP)) begin
          complete_s = 1'b1;
          state_next = brk_next_s ? ST_BRK_WAIT : ST_IDLE;
        end else begin
          state_next = ST_STOP;
        end
      end
      ST_BRK_WAIT: begin
        if (rxd_s) state_next = ST_IDLE;
        else       state_next = ST_BRK_WAIT;
      end
      default: state_next = ST_IDLE;
    endcase
    // Restart the bit timer on every state entry and after every bit tick.
    load_s = (state_next != state_r) || tick_s;
  end

  // Frame datapath: bit counter, shift register and per-frame error flags.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      bit_cnt_r <= {BW{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      brk_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_START: begin
          if (half_tick) begin
            bit_cnt_r <= {BW{1'b0}};
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            brk_r     <= 1'b0;
          end
        end
        ST_DATA: begin
          if (full_tick) begin
            shift_r[bit_cnt_r] <= rxd_s;
            bit_cnt_r <= (bit_cnt_r == LAST_DATA) ? {BW{1'b0}} : bit_cnt_r + BW'(1);
          end
        end
        ST_PARITY: begin
          if (full_tick) begin
            if (PMODE == PARITY_ODD) perr_r <= ~(^shift_r ^ rxd_s);
            else                     perr_r <= ^shift_r ^ rxd_s;
          end
        end
        ST_STOP: begin
          if (full_tick) begin
            ferr_r    <= ferr_next_s;
            brk_r     <= brk_next_s;
            bit_cnt_r <= bit_cnt_r + BW'(1);
          end
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end
  end

  // Output register: loads a completed frame when free (or being freed this
  // edge), otherwise drops it and pulses OVERRUN; VALID clears on accept.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      DATA       <= {DATA_BITS{1'b0}};
      VALID      <= 1'b0;
      PARITY_ERR <= 1'b0;
      FRAME_ERR  <= 1'b0;
      BREAK      <= 1'b0;
      OVERRUN    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      OVERRUN <= 1'b0;
      BUSY    <= (state_next != ST_IDLE);
      if (complete_s) begin
        if (!VALID || READY) begin
          DATA       <= shift_r;
          PARITY_ERR <= perr_r;
          FRAME_ERR  <= ferr_next_s;
          BREAK      <= brk_next_s;
          VALID      <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: four instances (8N1, 8E1, 8O1, 5N2)
// at 16 clocks per bit, with a scoreboard of expected received words.
module tb_uart_rx_param;

  typedef struct packed {
    logic [1:0] idx;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rxd, rdy;
  logic [3:0] vld, pe, fe, bk, ov, bsy;
  logic [7:0] d0, d1, d2;
  logic [4:0] d3;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sbq[$];
  int   ovr_cnt[4];
  int   vhigh[4];
  int   rise_cyc[4];
  logic [3:0] vld_q;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .CLK(clk), .RESET(reset), .RXD(rxd[0]), .DATA(d0), .VALID(vld[0]), .READY(rdy[0]),
    .PARITY_ERR(pe[0]), .FRAME_ERR(fe[0]), .BREAK(bk[0]), .OVERRUN(ov[0]), .BUSY(bsy[0]));
  uart_rx_param #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .CLK(clk), .RESET(reset), .RXD(rxd[1]), .DATA(d1), .VALID(vld[1]), .READY(rdy[1]),
    .PARITY_ERR(pe[1]), .FRAME_ERR(fe[1]), .BREAK(bk[1]), .OVERRUN(ov[1]), .BUSY(bsy[1]));
  uart_rx_param #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
    .CLK(clk), .RESET(reset), .RXD(rxd[2]), .DATA(d2), .VALID(vld[2]), .READY(rdy[2]),
    .PARITY_ERR(pe[2]), .FRAME_ERR(fe[2]), .BREAK(bk[2]), .OVERRUN(ov[2]), .BUSY(bsy[2]));
  uart_rx_param #(.CLKS_PER_BIT(BIT), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
    .CLK(clk), .RESET(reset), .RXD(rxd[3]), .DATA(d3), .VALID(vld[3]), .READY(rdy[3]),
    .PARITY_ERR(pe[3]), .FRAME_ERR(fe[3]), .BREAK(bk[3]), .OVERRUN(ov[3]), .BUSY(bsy[3]));

  function automatic logic [8:0] get_d(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {1'b0, d2};
      default: return {4'b0, d3};
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input int idx, input logic [8:0] d,
                             input logic p, input logic f, input logic b);
    exp_t e;
    e.idx = 2'(idx); e.d = d; e.pe = p; e.fe = f; e.bk = b;
    sbq.push_back(e);
  endtask

  // Drive one frame on line idx: start, nd data bits LSB first, optional
  // parity bit, then ns stop bits taken from stops[0], stops[1].
  task automatic send_frame(input int idx, input logic [8:0] d, input int nd,
                            input int has_par, input logic pbit,
                            input logic [1:0] stops, input int ns);
    logic [15:0] f;
    int len;
    f = 16'hFFFF;
    f[0] = 1'b0;
    for (int k = 0; k < nd; k++) f[1 + k] = d[k];
    len = 1 + nd;
    if (has_par != 0) begin f[len] = pbit; len++; end
    for (int s = 0; s < ns; s++) begin f[len] = stops[s]; len++; end
    for (int b = 0; b < len; b++) begin
      rxd[idx] = f[b];
      tick(BIT);
    end
    rxd[idx] = 1'b1;
  endtask

  // Scoreboard monitor: compares every accepted word and tracks VALID/OVERRUN.
  task automatic monitor_loop();
    exp_t e, o;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int i = 0; i < 4; i++) begin
          if (ov[i]) ovr_cnt[i]++;
          if (vld[i]) vhigh[i]++;
          if (vld[i] && !vld_q[i]) rise_cyc[i] = cyc;
          if (vld[i] && rdy[i]) begin
            vectors++;
            o.idx = 2'(i); o.d = get_d(i); o.pe = pe[i]; o.fe = fe[i]; o.bk = bk[i];
            if (sbq.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_word inst=%0d got d=%h pe=%b fe=%b bk=%b, required no word",
                       i, o.d, o.pe, o.fe, o.bk);
            end else begin
              e = sbq.pop_front();
              if (o !== e) begin
                miscompares++;
                $display("FAIL word got inst=%0d d=%h pe=%b fe=%b bk=%b, required inst=%0d d=%h pe=%b fe=%b bk=%b",
                         o.idx, o.d, o.pe, o.fe, o.bk, e.idx, e.d, e.pe, e.fe, e.bk);
              end
            end
          end
        end
      end
      vld_q = vld;
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL %s pending=%0d required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; rxd = 4'hF; rdy = 4'h0;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({vld[i], pe[i], fe[i], bk[i], ov[i], bsy[i], get_d(i)} !== 15'd0) begin
        miscompares++;
        $display("FAIL reset_outputs inst=%0d got v=%b pe=%b fe=%b bk=%b ov=%b busy=%b d=%h, required all 0",
                 i, vld[i], pe[i], fe[i], bk[i], ov[i], bsy[i], get_d(i));
      end
    end
    reset = 1'b1;
    tick(2);
    vld_q = vld;
    mon_en = 1'b1;
  endtask

  task automatic test_8n1();
    logic [7:0] pats [4] = '{8'hA5, 8'h00, 8'hFF, 8'h81};
    int t0, vh0;
    rdy[0] = 1'b1;
    foreach (pats[n]) begin
      expect_word(0, {1'b0, pats[n]}, 1'b0, 1'b0, 1'b0);
      vh0 = vhigh[0];
      t0 = cyc;
      send_frame(0, {1'b0, pats[n]}, 8, 0, 1'b0, 2'b11, 1);
      tick(20);
      check_drained("8n1_word");
      vectors++;
      if (vhigh[0] - vh0 != 1) begin
        miscompares++;
        $display("FAIL 8n1_valid_width got %0d cycles required 1", vhigh[0] - vh0);
      end
      if (n == 0) begin
        // 2 sync + 1 detect + 8 half bit + 8 data bits + 1 stop bit.
        vectors++;
        if (rise_cyc[0] - t0 != 2 + 1 + BIT / 2 + 8 * BIT + BIT) begin
          miscompares++;
          $display("FAIL 8n1_latency got %0d required %0d", rise_cyc[0] - t0,
                   2 + 1 + BIT / 2 + 8 * BIT + BIT);
        end
      end
    end
  endtask

  task automatic test_parity();
    rdy[1] = 1'b1; rdy[2] = 1'b1;
    expect_word(1, 9'h007, 1'b1, 1'b0, 1'b0);
    send_frame(1, 9'h007, 8, 1, 1'b0, 2'b11, 1); tick(20);
    expect_word(1, 9'h007, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h007, 8, 1, 1'b1, 2'b11, 1); tick(20);
    expect_word(2, 9'h007, 1'b0, 1'b0, 1'b0);
    send_frame(2, 9'h007, 8, 1, 1'b0, 2'b11, 1); tick(20);
    expect_word(2, 9'h007, 1'b1, 1'b0, 1'b0);
    send_frame(2, 9'h007, 8, 1, 1'b1, 2'b11, 1); tick(20);
    check_drained("parity_words");
  endtask

  task automatic test_glitch();
    rdy[0] = 1'b1;
    rxd[0] = 1'b0;
    tick(5);
    rxd[0] = 1'b1;
    vectors++;
    if (bsy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_busy_high got %b required 1", bsy[0]);
    end
    tick(6);
    vectors++;
    if (bsy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_busy_low got %b required 0", bsy[0]);
    end
    tick(40);
    check_drained("glitch_no_word");
  endtask

  task automatic test_break();
    int vh0;
    rdy[0] = 1'b1;
    vh0 = vhigh[0];
    expect_word(0, 9'h000, 1'b0, 1'b1, 1'b1);
    rxd[0] = 1'b0;
    tick(30 * BIT);
    check_drained("break_word");
    vectors++;
    if (bsy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL break_hold_busy got %b required 1", bsy[0]);
    end
    rxd[0] = 1'b1;
    tick(40);
    vectors++;
    if (bsy[0] !== 1'b0 || vhigh[0] - vh0 != 1) begin
      miscompares++;
      $display("FAIL break_single got busy=%b words=%0d required busy=0 words=1",
               bsy[0], vhigh[0] - vh0);
    end
  endtask

  task automatic test_overrun();
    int o0;
    rdy[0] = 1'b0;
    expect_word(0, 9'h011, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, 0, 1'b0, 2'b11, 1); tick(8);
    o0 = ovr_cnt[0];
    send_frame(0, 9'h022, 8, 0, 1'b0, 2'b11, 1); tick(8);
    vectors++;
    if (ovr_cnt[0] - o0 != 1 || d0 !== 8'h11 || vld[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun got pulses=%0d d=%h v=%b required pulses=1 d=11 v=1",
               ovr_cnt[0] - o0, d0, vld[0]);
    end
    rdy[0] = 1'b1;
    tick(1);
    vectors++;
    if (vld[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_accept got v=%b required 0", vld[0]);
    end
    check_drained("overrun_word");
  endtask

  task automatic test_reset_mid();
    logic [3:0] head;
    rdy[0] = 1'b0;
    send_frame(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1); tick(4);
    head = 4'b1000;                           // start, 0x3C bits 0..2 = 0,0,1
    for (int b = 0; b < 4; b++) begin rxd[0] = head[b]; tick(BIT); end
    rxd[0] = 1'b1;                            // bit 3 of 0x3C, half way through
    tick(BIT / 2);
    reset = 1'b0;
    tick(1);
    vectors++;
    if ({vld[0], pe[0], fe[0], bk[0], ov[0], bsy[0], d0} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_mid got v=%b pe=%b fe=%b bk=%b ov=%b busy=%b d=%h required all 0",
               vld[0], pe[0], fe[0], bk[0], ov[0], bsy[0], d0);
    end
    reset = 1'b1;
    tick(10 * BIT);
    rdy[0] = 1'b1;
    expect_word(0, 9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1); tick(20);
    check_drained("reset_recover");
  endtask

  task automatic test_5n2();
    rdy[3] = 1'b1;
    expect_word(3, 9'h015, 1'b0, 1'b0, 1'b0);
    send_frame(3, 9'h015, 5, 0, 1'b0, 2'b11, 2); tick(20);
    expect_word(3, 9'h00A, 1'b0, 1'b1, 1'b0);
    send_frame(3, 9'h00A, 5, 0, 1'b0, 2'b01, 2); tick(40);
    check_drained("5n2_words");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ovr_cnt[i] = 0; vhigh[i] = 0; rise_cyc[i] = 0;
    end
    vld_q = 4'h0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_mid();
    test_5n2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #3000000;
    $display("FAIL timeout simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
